alu_bist_engine: RTL and testbench
==================================

// Module: alu_bist_engine
// PURPOSE
// ALU-side BIST responder. Serves the BIST controller's run request.
// - On request, drives LFSR pseudo-random operands and opcodes into the ALU under test.
// - Compacts each ALU result into a MISR.
// - Compares the final signature against a golden value and reports done/pass/fail.
// Sits between the BIST controller and the ALU datapath mux (alu_bist_en selects the test operands).
// PARAMETERS
// DATA_W        8             ALU operand/result width; 2*DATA_W+OP_W <= 32
// OP_W          3             ALU opcode width
// NUM_PATTERNS  256           patterns applied per run, legal range 1..65535
// ALU_LAT       1             ALU result latency in clk cycles, legal range 1..4
// LFSR_SEED     32'hACE1_2468 LFSR start value; a zero seed is replaced by 32'h0000_0001
// GOLDEN_SIG    16'h0000      expected final MISR signature
// PORTS
// clk          in   1        clock, rising edge
// reset        in   1        asynchronous, active-high
// run_req      in   1        controller request level; rising edge starts a run
// run_ack      out  1        high while a run is in progress or being reported
// alu_bist_en  out  1        high while operands are being driven (GEN state only)
// alu_a        out  DATA_W   test operand A
// alu_b        out  DATA_W   test operand B
// alu_op       out  OP_W     test opcode
// alu_result   in   DATA_W   ALU result, valid ALU_LAT cycles after its operands
// signature    out  16       current MISR contents
// done         out  1        run complete
// pass         out  1        signature == GOLDEN_SIG
// fail         out  1        signature != GOLDEN_SIG
// BEHAVIOUR
// Reset: state=IDLE; all outputs 0; lfsr=seed; misr=0; counters=0; run_req_q=0.
// Start detect:
// - Registered run_req_q; start = run_req & ~run_req_q.
// - Start is honoured only in IDLE.
// States IDLE, GEN, DRAIN, CMP, REPORT:
// - IDLE: on start, load lfsr=seed, misr=0, pat_cnt=0 -> GEN.
// - GEN: alu_bist_en=1 and run_ack=1.
//   - alu_a = lfsr[DATA_W-1:0]
//   - alu_b = lfsr[2*DATA_W-1:DATA_W]
//   - alu_op = lfsr[2*DATA_W+OP_W-1:2*DATA_W]
//   - lfsr advances every cycle.
//   - pat_cnt increments every cycle.
//   - After NUM_PATTERNS GEN cycles (pat_cnt==NUM_PATTERNS-1), go to DRAIN.
// - DRAIN: alu_bist_en=0; alu_a/b/op hold their last value; stay ALU_LAT cycles -> CMP.
// - CMP: one cycle, compare misr to GOLDEN_SIG -> REPORT.
// - REPORT: done=1 and run_ack=1.
//   - Exactly one of pass/fail is 1.
//   - Outputs hold while run_req=1.
//   - When run_req=0, go to IDLE and clear done, pass, fail and run_ack.
// LFSR:
// - 32-bit Fibonacci LFSR, taps 32,22,2,1; shift left; new bit at [0] = b31^b21^b1^b0.
// - Never reaches zero.
// Capture:
// - A valid shift register of depth ALU_LAT is fed with (state==GEN).
// - On a valid output bit, fold alu_result into the MISR.
// - Exactly NUM_PATTERNS results are compacted per run.
// MISR:
// - 16-bit, polynomial x^16+x^12+x^5+1.
// - next = {misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 0) ^ zero-extended alu_result.
// - If DATA_W>16, fold in alu_result[15:0] only.
// - signature = misr, visible at all times.
// Abort: run_req=0 in GEN, DRAIN or CMP -> IDLE next cycle.
// - done=pass=fail=0.
// - alu_bist_en=0.
// - MISR is retained but ignored.
// Simultaneous events:
// - reset dominates everything.
// - A rising edge of run_req outside IDLE is ignored. A new run needs a fall, then a rise.
// Pass and fail are never high together. Both are 0 whenever done=0.
// Latency: start edge to done = 1 + NUM_PATTERNS + ALU_LAT + 1 cycles.
// TESTING
// T1:
// - Stimulus: default params, ALU model = a+b, GOLDEN_SIG from the bench's reference model; pulse run_req high and hold.
// - Response: done=1 and pass=1 at cycle 1+256+1+1=259 after the edge; exactly 256 cycles with alu_bist_en=1.
// T2:
// - Stimulus: same run with GOLDEN_SIG off by one bit.
// - Response: done=1, fail=1, pass=0; signature equals the model value.
// T3:
// - Stimulus: drop run_req at GEN cycle 100.
// - Response: next cycle IDLE; alu_bist_en=0, done=pass=fail=0. A later rising edge runs a full 256 patterns and passes.
// T4:
// - Stimulus: assert reset at GEN cycle 50, release, then raise run_req.
// - Response: all outputs 0 during reset; the new run matches T1 exactly, including signature and alu_a/alu_b sequence.
// T5:
// - Stimulus: NUM_PATTERNS=1, ALU_LAT=3, LFSR_SEED=0.
// - Response: first alu_a/alu_b/alu_op come from lfsr=32'h1; done arrives 6 cycles after the edge; one value is compacted.
// T6:
// - Stimulus: hold run_req high in REPORT for 20 cycles, then drop it.
// - Response: done/pass hold for all 20 cycles; IDLE and outputs 0 on the next cycle; no restart without a new rising edge.

Source files
------------

// File: rtl/alu_bist_engine.sv
// rtl/alu_bist_engine.sv - ALU BIST responder: LFSR operand generator, MISR compactor, signature check
module alu_bist_engine #(
  parameter int          DATA_W       = 8,
  parameter int          OP_W         = 3,
  parameter int          NUM_PATTERNS = 256,
  parameter int          ALU_LAT      = 1,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_req,
  output logic              run_ack,
  output logic              alu_bist_en,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [15:0]       signature,
  output logic              done,
  output logic              pass,
  output logic              fail
);

  typedef enum logic [2:0] {IDLE, GEN, DRAIN, CMP, REPORT} state_t;

  localparam logic [31:0] SEED     = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [15:0] LAST_PAT = 16'(NUM_PATTERNS - 1);
  localparam logic [2:0]  LAST_LAT = 3'(ALU_LAT - 1);

  state_t              state, state_nx;
  logic                run_req_q;
  logic                start;
  logic [31:0]         lfsr;
  logic [15:0]         misr;
  logic [15:0]         misr_nx;
  logic [15:0]         res16;
  logic [15:0]         pat_cnt;
  logic [2:0]          lat_cnt;
  logic [ALU_LAT-1:0]  vld_sr;
  logic                sig_ok;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [OP_W-1:0]     op_q;

  assign start = run_req & ~run_req_q;

  // Only the low 16 result bits reach the MISR on wide datapaths
  if (DATA_W >= 16) begin : g_res_wide
    assign res16 = alu_result[15:0];
  end else begin : g_res_narrow
    assign res16 = {{(16-DATA_W){1'b0}}, alu_result};
  end

  assign misr_nx = {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ res16;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = GEN;
      GEN:     if (!run_req) state_nx = IDLE;
               else if (pat_cnt == LAST_PAT) state_nx = DRAIN;
      DRAIN:   if (!run_req) state_nx = IDLE;
               else if (lat_cnt == LAST_LAT) state_nx = CMP;
      CMP:     if (!run_req) state_nx = IDLE;
               else state_nx = REPORT;
      REPORT:  if (!run_req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign alu_bist_en = (state == GEN);
  assign run_ack     = (state != IDLE);
  assign done        = (state == REPORT);
  assign pass        = done & sig_ok;
  assign fail        = done & ~sig_ok;
  assign signature   = misr;

  // Operands come straight from the LFSR while generating and freeze afterwards
  assign alu_a  = alu_bist_en ? lfsr[DATA_W-1:0]                 : a_q;
  assign alu_b  = alu_bist_en ? lfsr[2*DATA_W-1:DATA_W]          : b_q;
  assign alu_op = alu_bist_en ? lfsr[2*DATA_W+OP_W-1:2*DATA_W]   : op_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_req_q <= 1'b0;
      lfsr      <= SEED;
      misr      <= 16'h0000;
      pat_cnt   <= 16'h0000;
      lat_cnt   <= 3'd0;
      vld_sr    <= '0;
      sig_ok    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
    end else begin
      run_req_q <= run_req;
      vld_sr[0] <= (state == GEN);
      for (int i = 1; i < ALU_LAT; i++) vld_sr[i] <= vld_sr[i-1];
      if (state == GEN) begin
        lfsr    <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
        pat_cnt <= pat_cnt + 16'd1;
        a_q     <= alu_a;
        b_q     <= alu_b;
        op_q    <= alu_op;
      end
      if (state == DRAIN) lat_cnt <= lat_cnt + 3'd1;
      else                lat_cnt <= 3'd0;
      if (state != IDLE && vld_sr[ALU_LAT-1]) misr <= misr_nx;
      if (state == CMP) sig_ok <= (misr == GOLDEN_SIG);
      // Stale valid bits from an aborted run must not leak into the new one
      if (state == IDLE && start) begin
        lfsr    <= SEED;
        misr    <= 16'h0000;
        pat_cnt <= 16'h0000;
        vld_sr  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_bist_engine.sv
// tb/tb_alu_bist_engine.sv - self-checking bench for alu_bist_engine
module tb_alu_bist_engine;

  function automatic logic [15:0] ref_sig(input logic [31:0] seed, input int n);
    logic [31:0] l;
    logic [15:0] m;
    logic [7:0]  r;
    l = (seed == 32'h0) ? 32'h1 : seed;
    m = 16'h0;
    for (int i = 0; i < n; i++) begin
      r = l[7:0] + l[15:8];
      m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {8'h00, r};
      l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    end
    return m;
  endfunction

  localparam logic [31:0] SEED  = 32'hACE1_2468;
  localparam logic [15:0] GOLD  = ref_sig(SEED, 256);
  localparam logic [15:0] GOLD5 = ref_sig(32'h0, 1);

  logic clk, reset, run_req, run_req5;

  logic       ack, en, done, pass, fail;
  logic [7:0] a, b, res;
  logic [2:0] op;
  logic [15:0] sig;

  logic       f_ack, f_en, f_done, f_pass, f_fail;
  logic [7:0] f_a, f_b, f_res;
  logic [2:0] f_op;
  logic [15:0] f_sig;

  logic       ack5, en5, done5, pass5, fail5;
  logic [7:0] a5, b5, p0, p1, p2;
  logic [2:0] op5;
  logic [15:0] sig5;

  alu_bist_engine #(.GOLDEN_SIG(GOLD)) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .run_ack(ack), .alu_bist_en(en),
    .alu_a(a), .alu_b(b), .alu_op(op), .alu_result(res), .signature(sig),
    .done(done), .pass(pass), .fail(fail));

  alu_bist_engine #(.GOLDEN_SIG(GOLD ^ 16'h0001)) dut_f (
    .clk(clk), .reset(reset), .run_req(run_req), .run_ack(f_ack), .alu_bist_en(f_en),
    .alu_a(f_a), .alu_b(f_b), .alu_op(f_op), .alu_result(f_res), .signature(f_sig),
    .done(f_done), .pass(f_pass), .fail(f_fail));

  alu_bist_engine #(.NUM_PATTERNS(1), .ALU_LAT(3), .LFSR_SEED(32'h0), .GOLDEN_SIG(GOLD5)) dut5 (
    .clk(clk), .reset(reset), .run_req(run_req5), .run_ack(ack5), .alu_bist_en(en5),
    .alu_a(a5), .alu_b(b5), .alu_op(op5), .alu_result(p2), .signature(sig5),
    .done(done5), .pass(pass5), .fail(fail5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU models: a+b with one cycle latency, and a three-stage version for dut5
  always @(posedge clk) begin
    res   <= a + b;
    f_res <= f_a + f_b;
    p0    <= a5 + b5;
    p1    <= p0;
    p2    <= p1;
  end

  typedef struct {
    int   cyc;
    logic en, ack, done, pass;
  } chk_t;

  chk_t tab[6];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_and_check(input string tag);
    logic [31:0] ml;
    logic [18:0] last;
    int en_cnt, seq_err, excl_err;
    ml = SEED; last = '0; en_cnt = 0; seq_err = 0; excl_err = 0;
    run_req = 1'b1;
    for (int c = 1; c <= 259; c++) begin
      tick();
      if (en) begin
        en_cnt++;
        if ({op, b, a} !== ml[18:0]) seq_err++;
        last = ml[18:0];
        ml = {ml[30:0], ml[31] ^ ml[21] ^ ml[1] ^ ml[0]};
      end
      if ((pass && fail) || (f_pass && f_fail) || (!done && (pass || fail))) excl_err++;
      if (c == 257) check($sformatf("%s drain_hold", tag), {13'h0, op, b, a}, {13'h0, last});
      for (int t = 0; t < 6; t++) begin
        if (tab[t].cyc == c) begin
          check($sformatf("%s en@%0d", tag, c), en, tab[t].en);
          check($sformatf("%s ack@%0d", tag, c), ack, tab[t].ack);
          check($sformatf("%s done@%0d", tag, c), done, tab[t].done);
          check($sformatf("%s pass@%0d", tag, c), pass, tab[t].pass);
        end
      end
    end
    check($sformatf("%s en_cycles", tag), en_cnt, 256);
    check($sformatf("%s operand_seq_errs", tag), seq_err, 0);
    check($sformatf("%s pass_fail_excl_errs", tag), excl_err, 0);
    check($sformatf("%s fail", tag), fail, 1'b0);
    check($sformatf("%s signature", tag), sig, GOLD);
    check($sformatf("%s bad_golden done/pass/fail", tag), {f_done, f_pass, f_fail}, 3'b101);
    check($sformatf("%s bad_golden signature", tag), f_sig, GOLD);
  endtask

  initial begin
    int d, errs;
    tab[0] = '{1,   1'b1, 1'b1, 1'b0, 1'b0};
    tab[1] = '{128, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[2] = '{256, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[3] = '{257, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[4] = '{258, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[5] = '{259, 1'b0, 1'b1, 1'b1, 1'b1};

    reset = 1'b1; run_req = 1'b0; run_req5 = 1'b0;
    tick(); tick();
    check("reset ctrl", {ack, en, done, pass, fail}, 5'b0);
    check("reset operands", {op, b, a}, 19'h0);
    check("reset signature", sig, 16'h0);
    reset = 1'b0;
    tick();

    // T1 + T2
    run_and_check("t1");

    // T6: hold in REPORT for 20 cycles, then release
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!(done && pass && !fail && ack)) errs++;
    end
    check("t6 report_hold_errs", errs, 0);
    run_req = 1'b0;
    tick();
    check("t6 idle_after_drop", {ack, en, done, pass, fail}, 5'b0);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack || en || done) errs++;
    end
    check("t6 no_restart_errs", errs, 0);

    // T3: abort at GEN cycle 100, then a full run
    run_req = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    check("t3 in_gen@100", en, 1'b1);
    run_req = 1'b0;
    tick();
    check("t3 abort_idle", {ack, en, done, pass, fail}, 5'b0);
    tick();
    run_and_check("t3");
    run_req = 1'b0;
    tick();

    // Random abort point anywhere in GEN, DRAIN or CMP
    d = $urandom_range(1, 258);
    run_req = 1'b1;
    for (int i = 0; i < d; i++) tick();
    check($sformatf("rand_abort ack@%0d", d), ack, 1'b1);
    run_req = 1'b0;
    tick();
    check($sformatf("rand_abort idle@%0d", d), {ack, en, done, pass, fail}, 5'b0);
    tick();

    // T4: reset at GEN cycle 50
    run_req = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    reset = 1'b1;
    #1;
    check("t4 reset ctrl", {ack, en, done, pass, fail}, 5'b0);
    check("t4 reset operands", {op, b, a}, 19'h0);
    check("t4 reset signature", sig, 16'h0);
    run_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    run_and_check("t4");
    run_req = 1'b0;
    tick();

    // T5: single pattern, latency 3, zero seed
    run_req5 = 1'b1;
    tick();
    check("t5 first_operands", {en5, op5, b5, a5}, {1'b1, 3'h0, 8'h00, 8'h01});
    tick();
    check("t5 drain_hold", {en5, ack5, op5, b5, a5}, {1'b0, 1'b1, 3'h0, 8'h00, 8'h01});
    tick(); tick(); tick();
    check("t5 done@5", done5, 1'b0);
    tick();
    check("t5 done/pass/fail@6", {done5, pass5, fail5}, 3'b110);
    check("t5 signature", sig5, 16'h0001);
    run_req5 = 1'b0;
    tick();
    check("t5 idle", {ack5, done5, pass5, fail5}, 4'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
